// File: rtl/module_test_counter.sv
// Prescaled, free-running 6-bit wrapping event counter.
// Define MODULE_TEST_GRAY_EN to emit a registered Gray-coded count on count_o.
module module_test_counter #(
   parameter int unsigned DIVIDER   = 10,
   parameter int unsigned COUNT_MAX = 63
) (
   input  logic       clk,
   input  logic       rst,
   output logic [5:0] count_o
);

   localparam int unsigned PrescW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(DIVIDER - 1);
   localparam logic [5:0] CntMax = 6'(COUNT_MAX);

   if (DIVIDER < 1 || DIVIDER > 65535) begin : g_divider_err
      $error("module_test_counter: DIVIDER out of range 1..65535");
   end
   if (COUNT_MAX < 1 || COUNT_MAX > 63) begin : g_count_max_err
      $error("module_test_counter: COUNT_MAX out of range 1..63");
   end

   logic [PrescW-1:0] presc_q, presc_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              tick;

   always_comb begin
      tick    = (presc_q == PrescLast);
      presc_d = tick ? '0 : presc_q + PrescW'(1);
      cnt_d   = cnt_q;
      if (tick) begin
         cnt_d = (cnt_q == CntMax) ? 6'd0 : cnt_q + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MODULE_TEST_GRAY_EN
   // Encode the next count so the Gray output lines up with cnt_q.
   logic [5:0] gray_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q <= '0;
      end else begin
         gray_q <= cnt_d ^ (cnt_d >> 1);
      end
   end

   assign count_o = gray_q;
`else
   assign count_o = cnt_q;
`endif

endmodule

// File: tb/tb_module_test_counter.sv
// Bench for module_test_counter: default instance plus a DIVIDER=1, COUNT_MAX=9 instance.
// Expected counts come from an edge-count formula and a table of fixed checkpoints.
module tb_module_test_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] count_main;
   logic [5:0] count_fast;

   always #5 clk = ~clk;

   module_test_counter #(
      .DIVIDER  (10),
      .COUNT_MAX(63)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .count_o(count_main)
   );

   module_test_counter #(
      .DIVIDER  (1),
      .COUNT_MAX(9)
   ) dut_fast (
      .clk    (clk),
      .rst    (rst),
      .count_o(count_fast)
   );

   typedef struct {
      int unsigned edge_no;
      logic [5:0]  exp_main;
      logic [5:0]  exp_fast;
   } vec_t;

   typedef struct {
      logic [5:0] exp_main;
      logic [5:0] exp_fast;
   } sb_t;

   vec_t        vecs[12];
   sb_t         sbq[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_edges = 0;
   logic [5:0]  prev_main = '0;
   logic        prev_rst  = 1'b1;

   function automatic logic [5:0] enc(input logic [5:0] b);
`ifdef MODULE_TEST_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   function automatic logic [5:0] model(input int unsigned n, input int unsigned div,
                                        input int unsigned cmax);
      return 6'((n / div) % (cmax + 1));
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n_edges, act, exp);
      end
   endtask

   // One clock edge: push the expectation, then pop and compare just after the edge.
   task automatic step(input logic r);
      sb_t e;
      logic [5:0] diff;
      rst = r;
      if (r) n_edges = 0;
      else   n_edges++;
      e.exp_main = r ? 6'd0 : enc(model(n_edges, 10, 63));
      e.exp_fast = r ? 6'd0 : enc(model(n_edges, 1, 9));
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check("main", count_main, e.exp_main);
      check("fast", count_fast, e.exp_fast);
`ifdef MODULE_TEST_GRAY_EN
      diff = count_main ^ prev_main;
      if (!r && !prev_rst && diff != 6'd0) begin
         check("gray_adjacent", 6'($countones(diff)), 6'd1);
      end
`else
      diff = '0;
`endif
      prev_main = count_main;
      prev_rst  = r;
   endtask

   initial begin
      int vi;
      vecs[0]  = '{edge_no: 1,   exp_main: 6'd0,  exp_fast: 6'd1};
      vecs[1]  = '{edge_no: 9,   exp_main: 6'd0,  exp_fast: 6'd9};
      vecs[2]  = '{edge_no: 10,  exp_main: 6'd1,  exp_fast: 6'd0};
      vecs[3]  = '{edge_no: 11,  exp_main: 6'd1,  exp_fast: 6'd1};
      vecs[4]  = '{edge_no: 19,  exp_main: 6'd1,  exp_fast: 6'd9};
      vecs[5]  = '{edge_no: 20,  exp_main: 6'd2,  exp_fast: 6'd0};
      vecs[6]  = '{edge_no: 30,  exp_main: 6'd3,  exp_fast: 6'd0};
      vecs[7]  = '{edge_no: 100, exp_main: 6'd10, exp_fast: 6'd0};
      vecs[8]  = '{edge_no: 630, exp_main: 6'd63, exp_fast: 6'd0};
      vecs[9]  = '{edge_no: 639, exp_main: 6'd63, exp_fast: 6'd9};
      vecs[10] = '{edge_no: 640, exp_main: 6'd0,  exp_fast: 6'd0};
      vecs[11] = '{edge_no: 650, exp_main: 6'd1,  exp_fast: 6'd0};

      // Reset held for three edges.
      for (int i = 0; i < 3; i++) step(1'b1);

      // Free run through the wrap, checking every edge plus the fixed checkpoints.
      vi = 0;
      for (int i = 0; i < 650; i++) begin
         step(1'b0);
         if (vi < 12 && n_edges == vecs[vi].edge_no) begin
            check("vec_main", count_main, enc(vecs[vi].exp_main));
            check("vec_fast", count_fast, enc(vecs[vi].exp_fast));
            vi++;
         end
      end
      check("vec_all_hit", 6'(vi), 6'd12);

      // Mid-run reset with count 5 and prescaler at 6.
      step(1'b1);
      for (int i = 0; i < 56; i++) step(1'b0);
      check("pre_mid_rst", count_main, enc(6'd5));
      step(1'b1);
      check("mid_rst", count_main, 6'd0);
      for (int i = 0; i < 9; i++) step(1'b0);
      check("mid_rst_edge9", count_main, 6'd0);
      step(1'b0);
      check("mid_rst_edge10", count_main, enc(6'd1));

      // Reset landing on the edge that would otherwise tick.
      step(1'b1);
      for (int i = 0; i < 9; i++) step(1'b0);
      step(1'b1);
      check("rst_on_tick_main", count_main, 6'd0);
      check("rst_on_tick_fast", count_fast, 6'd0);
      for (int i = 0; i < 12; i++) step(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/module_test_counter.md
# module_test_counter

Free-running, prescaled 6-bit event counter used as the timebase and activity indicator in the test top level. A clock-cycle prescaler divides `clk` by a fixed parameter. Each prescaler terminal count advances a wrapping 6-bit counter, whose value drives `count_o`. The block is purely synchronous and has no handshake.

## Interface
- `DIVIDER`, default 10: clock cycles per count step; legal range 1..2^16-1.
- `COUNT_MAX`, default 63: last value before wrap to 0; legal range 1..63.
- `clk`  input  1  rising-edge system clock.
- `rst`  input  1  reset; one clock, synchronous, active-high, sampled on the rising edge of `clk`.
- `count_o`  output  6  registered counter value; Gray-coded when `MODULE_TEST_GRAY_EN` is defined.

## Operation
- Internal registers:
  - `presc_q`: prescaler, width clog2(DIVIDER), minimum 1 bit.
  - `cnt_q`: 6-bit binary count.
- Reset (`rst`=1 at a clock edge): `presc_q`←0 and `cnt_q`←0, so `count_o`=0. Reset has priority over all counting.
- Normal operation (`rst`=0):
  - If `presc_q`==DIVIDER-1: `presc_q`←0 and a tick occurs.
  - Otherwise: `presc_q`←`presc_q`+1.
- On a tick:
  - If `cnt_q`==COUNT_MAX: `cnt_q`←0 (wrap).
  - Otherwise: `cnt_q`←`cnt_q`+1.
- DIVIDER=1: a tick occurs on every non-reset edge.
- No input other than `rst` affects counting; counting never stops.
- Arithmetic is unsigned. `cnt_q` never exceeds COUNT_MAX, and no overflow past 6 bits is possible.
- Out-of-range parameters halt elaboration with `$error`.

## Timing
- `count_o` is driven directly from a register, with no combinational path from any input.
- Reset latency: `count_o`=0 after the first rising edge with `rst`=1. It holds 0 for every edge while `rst` stays high.
- First tick: given a reset, the first edge with `rst`=0 is edge 1. `count_o` becomes 1 after edge DIVIDER; with the default, that is the 10th edge.
- Steady state: `count_o` changes exactly once every DIVIDER edges.
- Wrap: `count_o` returns to 0 after DIVIDER×(COUNT_MAX+1) post-reset edges; with the defaults, 640 edges.
- Reset mid-operation: any partial prescaler count is discarded. After release, the next step again takes exactly DIVIDER edges.
- Reset asserted on the same edge as a tick: reset wins, and `count_o`=0.
- Before the first reset, register contents are undefined. The bench must apply reset first.

## Configuration
- Macro `MODULE_TEST_GRAY_EN`:
  - Defined: `count_o` is the Gray code of the next `cnt_q`, computed as cnt ^ (cnt>>1) and registered, so it carries the same latency as the binary path. Reset value is 0.
  - Not defined: `count_o` = `cnt_q` in plain binary.
- Counting, ticks and wrap are identical in both builds.
- Note: Gray adjacency across the wrap holds only when COUNT_MAX+1 is a power of two.

## Test plan
- Hold `rst`=1 for 3 edges with the defaults → `count_o`=0 on every edge; it stays 0 for as long as `rst` remains high.
- Release `rst` with the defaults → `count_o`=0 through edge 9, 1 after edge 10, 10 after edge 100.
- Wrap with the defaults → `count_o`=63 after 630 edges and 0 after 640 edges; it is never greater than 63.
- Mid-run reset: assert `rst` for 1 edge when `count_o`=5 and `presc_q`=6 → `count_o`=0 on that edge. After release, 1 appears exactly 10 edges later.
- `MODULE_TEST_GRAY_EN` with the defaults:
  - After 30 edges (binary 3), `count_o`=6'b000010.
  - After 630 edges (binary 63), `count_o`=6'b100000.
  - Exactly one bit toggles per step.
- DIVIDER=1, COUNT_MAX=9 → `count_o` steps 1,2,…,9,0,1 on consecutive edges after release.
